// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: IDLE -> ISSUE -> WAIT -> ACK, one transaction at a time.
// Define ROUND_ROBIN_EN for alternating priority on contention; default is fixed priority (req0 first).
//
// state    | meaning
// ST_IDLE  | no transaction; arbitrate, latch winner's command, pulse its gnt
// ST_ISSUE | drive mem_enable for one cycle with the latched command
// ST_WAIT  | count WAIT_CYCLES, capture mem_dataout on the last cycle of a read
// ST_ACK   | pulse the winner's ack, return to IDLE
module mem_arbiter #(
   parameter int WAIT_CYCLES = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req0,
   input  logic       rw0,
   input  logic [3:0] addr0,
   input  logic [3:0] wdata0,
   output logic       gnt0,
   output logic       ack0,
   output logic [3:0] rdata0,
   input  logic       req1,
   input  logic       rw1,
   input  logic [3:0] addr1,
   input  logic [3:0] wdata1,
   output logic       gnt1,
   output logic       ack1,
   output logic [3:0] rdata1,
   output logic       mem_enable,
   output logic       mem_rw,
   output logic [3:0] mem_address,
   output logic [3:0] mem_datain,
   input  logic [3:0] mem_dataout,
   output logic       busy
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_ACK   = 2'd3
   } state_t;

   localparam logic [1:0] WAIT_LOAD = 2'(WAIT_CYCLES - 1);

   state_t     state_q, state_d;
   logic       owner_q, owner_d;
   logic       mem_rw_q, mem_rw_d;
   logic [3:0] mem_address_q, mem_address_d;
   logic [3:0] mem_datain_q, mem_datain_d;
   logic [1:0] cnt_q, cnt_d;
   logic [3:0] rdata0_q, rdata0_d;
   logic [3:0] rdata1_q, rdata1_d;

   logic win_valid;
   logic win_sel;

`ifdef ROUND_ROBIN_EN
   // prio_q names the requester that wins the next simultaneous request.
   logic prio_q, prio_d;

   always_comb begin
      win_valid = req0 | req1;
      if (req0 && req1) begin
         win_sel = prio_q;
      end else begin
         win_sel = req1;
      end
   end
`else
   always_comb begin
      win_valid = req0 | req1;
      win_sel   = ~req0 & req1;
   end
`endif

   always_comb begin
      state_d       = state_q;
      owner_d       = owner_q;
      mem_rw_d      = mem_rw_q;
      mem_address_d = mem_address_q;
      mem_datain_d  = mem_datain_q;
      cnt_d         = cnt_q;
      rdata0_d      = rdata0_q;
      rdata1_d      = rdata1_q;
`ifdef ROUND_ROBIN_EN
      prio_d        = prio_q;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (win_valid) begin
               owner_d       = win_sel;
               mem_rw_d      = win_sel ? rw1    : rw0;
               mem_address_d = win_sel ? addr1  : addr0;
               mem_datain_d  = win_sel ? wdata1 : wdata0;
               state_d       = ST_ISSUE;
`ifdef ROUND_ROBIN_EN
               prio_d        = ~win_sel;
`endif
            end
         end
         ST_ISSUE: begin
            cnt_d   = WAIT_LOAD;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (cnt_q == 2'd0) begin
               if (!mem_rw_q) begin
                  if (owner_q) begin
                     rdata1_d = mem_dataout;
                  end else begin
                     rdata0_d = mem_dataout;
                  end
               end
               state_d = ST_ACK;
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         ST_ACK: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         owner_q       <= 1'b0;
         mem_rw_q      <= 1'b0;
         mem_address_q <= 4'h0;
         mem_datain_q  <= 4'h0;
         cnt_q         <= 2'd0;
         rdata0_q      <= 4'h0;
         rdata1_q      <= 4'h0;
`ifdef ROUND_ROBIN_EN
         prio_q        <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         owner_q       <= owner_d;
         mem_rw_q      <= mem_rw_d;
         mem_address_q <= mem_address_d;
         mem_datain_q  <= mem_datain_d;
         cnt_q         <= cnt_d;
         rdata0_q      <= rdata0_d;
         rdata1_q      <= rdata1_d;
`ifdef ROUND_ROBIN_EN
         prio_q        <= prio_d;
`endif
      end
   end

   // Pulses are decoded from state; reset masks them so a request in a reset cycle is never granted.
   assign gnt0        = ~reset & (state_q == ST_IDLE) & win_valid & ~win_sel;
   assign gnt1        = ~reset & (state_q == ST_IDLE) & win_valid &  win_sel;
   assign ack0        = ~reset & (state_q == ST_ACK) & ~owner_q;
   assign ack1        = ~reset & (state_q == ST_ACK) &  owner_q;
   assign mem_enable  = ~reset & (state_q == ST_ISSUE);
   assign mem_rw      = mem_rw_q;
   assign mem_address = mem_address_q;
   assign mem_datain  = mem_datain_q;
   assign rdata0      = rdata0_q;
   assign rdata1      = rdata1_q;
   assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: WAIT_CYCLES=1 instance for most scenarios, WAIT_CYCLES=3 instance for early drop.
module tb_mem_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic       reset;
   logic       req0, rw0, req1, rw1;
   logic [3:0] addr0, wdata0, addr1, wdata1;
   logic       gnt0, ack0, gnt1, ack1;
   logic [3:0] rdata0, rdata1;
   logic       mem_enable, mem_rw, busy;
   logic [3:0] mem_address, mem_datain, mem_dataout;

   logic       b_req0, b_rw0, b_req1, b_rw1;
   logic [3:0] b_addr0, b_wdata0, b_addr1, b_wdata1;
   logic       b_gnt0, b_ack0, b_gnt1, b_ack1;
   logic [3:0] b_rdata0, b_rdata1;
   logic       b_mem_enable, b_mem_rw, b_busy;
   logic [3:0] b_mem_address, b_mem_datain, b_mem_dataout;

   mem_arbiter #(.WAIT_CYCLES(1)) u_dut (
      .clk(clk), .reset(reset),
      .req0(req0), .rw0(rw0), .addr0(addr0), .wdata0(wdata0),
      .gnt0(gnt0), .ack0(ack0), .rdata0(rdata0),
      .req1(req1), .rw1(rw1), .addr1(addr1), .wdata1(wdata1),
      .gnt1(gnt1), .ack1(ack1), .rdata1(rdata1),
      .mem_enable(mem_enable), .mem_rw(mem_rw), .mem_address(mem_address),
      .mem_datain(mem_datain), .mem_dataout(mem_dataout), .busy(busy)
   );

   mem_arbiter #(.WAIT_CYCLES(3)) u_dut3 (
      .clk(clk), .reset(reset),
      .req0(b_req0), .rw0(b_rw0), .addr0(b_addr0), .wdata0(b_wdata0),
      .gnt0(b_gnt0), .ack0(b_ack0), .rdata0(b_rdata0),
      .req1(b_req1), .rw1(b_rw1), .addr1(b_addr1), .wdata1(b_wdata1),
      .gnt1(b_gnt1), .ack1(b_ack1), .rdata1(b_rdata1),
      .mem_enable(b_mem_enable), .mem_rw(b_mem_rw), .mem_address(b_mem_address),
      .mem_datain(b_mem_datain), .mem_dataout(b_mem_dataout), .busy(b_busy)
   );

   // Memories: contents reset to addr ^ 0xA, read data registered one cycle after enable.
   logic [3:0] mem_a [16];
   logic [3:0] mem_b [16];
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 16; i++) mem_a[i] <= 4'(i) ^ 4'hA;
      end else if (mem_enable) begin
         if (mem_rw) mem_a[mem_address] <= mem_datain;
         else        mem_dataout <= mem_a[mem_address];
      end
   end
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 16; i++) mem_b[i] <= 4'(i) ^ 4'hA;
      end else if (b_mem_enable) begin
         if (b_mem_rw) mem_b[b_mem_address] <= b_mem_datain;
         else          b_mem_dataout <= mem_b[b_mem_address];
      end
   end

   typedef struct {
      logic       who;
      logic       rd;
      logic [3:0] data;
   } sb_t;
   sb_t sb[$];

   logic [3:0] sh [16];
   logic [3:0] exp_rdata0, exp_rdata1;
   int n_cmp = 0;
   int n_err = 0;

   task automatic model_reset();
      for (int i = 0; i < 16; i++) sh[i] = 4'(i) ^ 4'hA;
      exp_rdata0 = 4'h0;
      exp_rdata1 = 4'h0;
      sb.delete();
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b1; req0 = 1'b0; req1 = 1'b0; b_req0 = 1'b0; b_req1 = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      model_reset();
   endtask

   task automatic wait_ack(input bit dut3, output int at, output bit ok);
      ok = 1'b0;
      at = -1;
      for (int i = 0; i < 12 && !ok; i++) begin
         @(negedge clk);
         if (dut3 ? (b_ack0 | b_ack1) : (ack0 | ack1)) begin
            ok = 1'b1;
            at = cyc;
         end
      end
   endtask

   task automatic test_reset();
      int n, at; bit ok; sb_t e;
      reset = 1'b1; req0 = 1'b1; req1 = 1'b1; rw0 = 1'b0; addr0 = 4'h4;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if ({gnt0, gnt1, ack0, ack1, mem_enable, busy, mem_rw, rdata0, rdata1, mem_address, mem_datain} !== 23'd0) begin
         n_err++;
         $display("FAIL reset_values: got %h want 0", {gnt0, gnt1, ack0, ack1, mem_enable, busy, mem_rw, rdata0, rdata1, mem_address, mem_datain});
      end
      @(posedge clk); #1;
      reset = 1'b0; req1 = 1'b0;
      model_reset();
      sb.push_back('{who: 1'b0, rd: 1'b1, data: sh[4]});
      @(negedge clk);
      n = cyc;
      n_cmp++;
      if ({gnt0, gnt1} !== 2'b10) begin
         n_err++;
         $display("FAIL reset_release_gnt: got %b want 10", {gnt0, gnt1});
      end
      wait_ack(1'b0, at, ok);
      n_cmp++;
      if (at !== n + 3) begin
         n_err++;
         $display("FAIL reset_txn_ack_cycle: got %0d want %0d", at, n + 3);
      end
      if (ok) begin
         e = sb.pop_front();
         exp_rdata0 = e.data;
         n_cmp++;
         if (rdata0 !== e.data) begin
            n_err++;
            $display("FAIL reset_txn_rdata0: got %h want %h", rdata0, e.data);
         end
      end
      @(posedge clk); #1 req0 = 1'b0;
   endtask

   task automatic test_read();
      int n, at; bit ok; sb_t e;
      @(posedge clk); #1;
      req0 = 1'b1; rw0 = 1'b0; addr0 = 4'h3; wdata0 = 4'h0;
      sb.push_back('{who: 1'b0, rd: 1'b1, data: sh[3]});
      @(negedge clk);
      n = cyc;
      n_cmp++;
      if ({gnt0, gnt1, busy} !== 3'b100) begin
         n_err++;
         $display("FAIL read_gnt: got %b want 100", {gnt0, gnt1, busy});
      end
      @(negedge clk);
      n_cmp++;
      if ({mem_enable, mem_rw, mem_address, busy, gnt0} !== {1'b1, 1'b0, 4'h3, 1'b1, 1'b0}) begin
         n_err++;
         $display("FAIL read_issue: got %b want 1000111 0", {mem_enable, mem_rw, mem_address, busy, gnt0});
      end
      wait_ack(1'b0, at, ok);
      n_cmp++;
      if (at !== n + 3) begin
         n_err++;
         $display("FAIL read_ack_cycle: got %0d want %0d", at, n + 3);
      end
      if (ok) begin
         e = sb.pop_front();
         exp_rdata0 = e.data;
         n_cmp++;
         if ({ack0, ack1, rdata0, rdata1} !== {1'b1, 1'b0, e.data, exp_rdata1}) begin
            n_err++;
            $display("FAIL read_ack: got %h want %h", {ack0, ack1, rdata0, rdata1}, {1'b1, 1'b0, e.data, exp_rdata1});
         end
      end
      @(posedge clk); #1 req0 = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({ack0, busy, gnt0, rdata0} !== {3'b000, exp_rdata0}) begin
         n_err++;
         $display("FAIL read_hold: got %h want %h", {ack0, busy, gnt0, rdata0}, {3'b000, exp_rdata0});
      end
   endtask

   task automatic test_write();
      int n, at; bit ok; sb_t e;
      @(posedge clk); #1;
      req1 = 1'b1; rw1 = 1'b1; addr1 = 4'hA; wdata1 = 4'h5;
      sb.push_back('{who: 1'b1, rd: 1'b0, data: 4'h0});
      sh[10] = 4'h5;
      @(negedge clk);
      n = cyc;
      n_cmp++;
      if ({gnt0, gnt1} !== 2'b01) begin
         n_err++;
         $display("FAIL write_gnt: got %b want 01", {gnt0, gnt1});
      end
      @(negedge clk);
      n_cmp++;
      if ({mem_enable, mem_rw, mem_address, mem_datain} !== {1'b1, 1'b1, 4'hA, 4'h5}) begin
         n_err++;
         $display("FAIL write_issue: got %h want %h", {mem_enable, mem_rw, mem_address, mem_datain}, {1'b1, 1'b1, 4'hA, 4'h5});
      end
      @(negedge clk);
      n_cmp++;
      if ({mem_enable, mem_rw, mem_address, mem_datain} !== {1'b0, 1'b1, 4'hA, 4'h5}) begin
         n_err++;
         $display("FAIL write_hold_cmd: got %h want %h", {mem_enable, mem_rw, mem_address, mem_datain}, {1'b0, 1'b1, 4'hA, 4'h5});
      end
      wait_ack(1'b0, at, ok);
      n_cmp++;
      if (at !== n + 3) begin
         n_err++;
         $display("FAIL write_ack_cycle: got %0d want %0d", at, n + 3);
      end
      if (ok) begin
         e = sb.pop_front();
         n_cmp++;
         if ({ack0, ack1, e.who, rdata0, rdata1} !== {1'b0, 1'b1, 1'b1, exp_rdata0, exp_rdata1}) begin
            n_err++;
            $display("FAIL write_ack_rdata: got %h want %h", {ack0, ack1, e.who, rdata0, rdata1}, {1'b0, 1'b1, 1'b1, exp_rdata0, exp_rdata1});
         end
      end
      @(posedge clk); #1 req1 = 1'b0;
      @(posedge clk); #1;
      req1 = 1'b1; rw1 = 1'b0;
      sb.push_back('{who: 1'b1, rd: 1'b1, data: sh[10]});
      @(negedge clk);
      n = cyc;
      wait_ack(1'b0, at, ok);
      if (ok) begin
         e = sb.pop_front();
         exp_rdata1 = e.data;
         n_cmp++;
         if ({ack1, rdata1, rdata0} !== {1'b1, e.data, exp_rdata0}) begin
            n_err++;
            $display("FAIL write_readback: got %h want %h", {ack1, rdata1, rdata0}, {1'b1, e.data, exp_rdata0});
         end
      end else begin
         n_cmp++;
         n_err++;
         $display("FAIL write_readback_timeout: got no ack want ack1 by cycle %0d", n + 3);
      end
      @(posedge clk); #1 req1 = 1'b0;
   endtask

   task automatic test_reset_mid();
      int n, at; bit ok, seen_ack; sb_t e;
      @(posedge clk); #1;
      req0 = 1'b1; rw0 = 1'b0; addr0 = 4'h6;
      @(negedge clk);
      n = cyc;
      @(posedge clk);
      @(posedge clk); #1 reset = 1'b1;
      @(negedge clk);
      seen_ack = ack0 | ack1;
      @(posedge clk); #1;
      @(negedge clk);
      seen_ack = seen_ack | ack0 | ack1;
      n_cmp++;
      if ({gnt0, gnt1, ack0, ack1, mem_enable, busy, mem_rw, rdata0, rdata1, mem_address, mem_datain, seen_ack} !== 24'd0) begin
         n_err++;
         $display("FAIL reset_mid_values: got %h want 0", {gnt0, gnt1, ack0, ack1, mem_enable, busy, mem_rw, rdata0, rdata1, mem_address, mem_datain, seen_ack});
      end
      @(posedge clk); #1 reset = 1'b0;
      model_reset();
      sb.push_back('{who: 1'b0, rd: 1'b1, data: sh[6]});
      @(negedge clk);
      n_cmp++;
      if ({gnt0, cyc} !== {1'b1, n + 4}) begin
         n_err++;
         $display("FAIL reset_mid_regrant: got gnt0=%b cyc=%0d want gnt0=1 cyc=%0d", gnt0, cyc, n + 4);
      end
      n = cyc;
      wait_ack(1'b0, at, ok);
      n_cmp++;
      if (at !== n + 3) begin
         n_err++;
         $display("FAIL reset_mid_ack_cycle: got %0d want %0d", at, n + 3);
      end
      if (ok) begin
         e = sb.pop_front();
         exp_rdata0 = e.data;
         n_cmp++;
         if (rdata0 !== e.data) begin
            n_err++;
            $display("FAIL reset_mid_rdata0: got %h want %h", rdata0, e.data);
         end
      end
      @(posedge clk); #1 req0 = 1'b0;
   endtask

   task automatic test_contention();
      int n, at, last_ack; bit ok, rr; sb_t e;
      logic order [$];
`ifdef ROUND_ROBIN_EN
      rr = 1'b1;
      order = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
      rr = 1'b0;
      order = '{1'b0, 1'b1};
`endif
      do_reset();
      last_ack = 0;
      @(posedge clk); #1;
      req0 = 1'b1; rw0 = 1'b0; addr0 = 4'h1;
      req1 = 1'b1; rw1 = 1'b0; addr1 = 4'h2;
      for (int k = 0; k < order.size(); k++) begin
         @(negedge clk);
         n = cyc;
         n_cmp++;
         if ({gnt0, gnt1} !== (order[k] ? 2'b01 : 2'b10)) begin
            n_err++;
            $display("FAIL contention_gnt%0d: got %b want %b", k, {gnt0, gnt1}, order[k] ? 2'b01 : 2'b10);
         end
         if (k > 0) begin
            n_cmp++;
            if (n !== last_ack + 1) begin
               n_err++;
               $display("FAIL contention_gap%0d: got %0d want %0d", k, n, last_ack + 1);
            end
         end
         sb.push_back('{who: order[k], rd: 1'b1, data: order[k] ? sh[2] : sh[1]});
         wait_ack(1'b0, at, ok);
         if (ok) begin
            e = sb.pop_front();
            if (e.who) exp_rdata1 = e.data;
            else       exp_rdata0 = e.data;
            n_cmp++;
            if ({ack0, ack1, rdata0, rdata1} !== {~e.who, e.who, exp_rdata0, exp_rdata1}) begin
               n_err++;
               $display("FAIL contention_ack%0d: got %h want %h", k, {ack0, ack1, rdata0, rdata1}, {~e.who, e.who, exp_rdata0, exp_rdata1});
            end
         end else begin
            n_cmp++;
            n_err++;
            $display("FAIL contention_timeout%0d: got no ack want ack by cycle %0d", k, n + 3);
         end
         last_ack = at;
         @(posedge clk); #1;
         if (k == order.size() - 1) begin
            req0 = 1'b0; req1 = 1'b0;
         end else if (!rr) begin
            req0 = 1'b0;
         end
      end
   endtask

   task automatic test_back_to_back();
      int n, at; bit ok; sb_t e;
      @(posedge clk); #1;
      req0 = 1'b1; rw0 = 1'b1; addr0 = 4'h7; wdata0 = 4'hC;
      sb.push_back('{who: 1'b0, rd: 1'b0, data: 4'h0});
      sh[7] = 4'hC;
      @(negedge clk);
      n = cyc;
      @(posedge clk); #1;
      rw0 = 1'b0; addr0 = 4'h8; wdata0 = 4'h3;
      sb.push_back('{who: 1'b0, rd: 1'b1, data: sh[8]});
      @(negedge clk);
      n_cmp++;
      if ({mem_enable, mem_rw, mem_address, mem_datain} !== {1'b1, 1'b1, 4'h7, 4'hC}) begin
         n_err++;
         $display("FAIL late_change_issue: got %h want %h", {mem_enable, mem_rw, mem_address, mem_datain}, {1'b1, 1'b1, 4'h7, 4'hC});
      end
      wait_ack(1'b0, at, ok);
      n_cmp++;
      if (at !== n + 3) begin
         n_err++;
         $display("FAIL late_change_ack_cycle: got %0d want %0d", at, n + 3);
      end
      if (ok) begin
         e = sb.pop_front();
         n_cmp++;
         if ({ack0, e.rd, rdata0} !== {1'b1, 1'b0, exp_rdata0}) begin
            n_err++;
            $display("FAIL late_change_write_ack: got %h want %h", {ack0, e.rd, rdata0}, {1'b1, 1'b0, exp_rdata0});
         end
      end
      @(negedge clk);
      n_cmp++;
      if ({gnt0, cyc} !== {1'b1, at + 1}) begin
         n_err++;
         $display("FAIL b2b_regrant: got gnt0=%b cyc=%0d want gnt0=1 cyc=%0d", gnt0, cyc, at + 1);
      end
      n = cyc;
      @(negedge clk);
      n_cmp++;
      if ({mem_enable, mem_rw, mem_address} !== {1'b1, 1'b0, 4'h8}) begin
         n_err++;
         $display("FAIL b2b_issue: got %h want %h", {mem_enable, mem_rw, mem_address}, {1'b1, 1'b0, 4'h8});
      end
      wait_ack(1'b0, at, ok);
      if (ok) begin
         e = sb.pop_front();
         exp_rdata0 = e.data;
         n_cmp++;
         if ({ack0, rdata0, at} !== {1'b1, e.data, n + 3}) begin
            n_err++;
            $display("FAIL b2b_read_ack: got ack0=%b rdata0=%h cyc=%0d want 1 %h %0d", ack0, rdata0, at, e.data, n + 3);
         end
      end else begin
         n_cmp++;
         n_err++;
         $display("FAIL b2b_timeout: got no ack want ack0 by cycle %0d", n + 3);
      end
      @(posedge clk); #1 req0 = 1'b0;
   endtask

   task automatic test_early_drop();
      int n, at; bit ok; sb_t e;
      @(posedge clk); #1;
      b_req0 = 1'b1; b_rw0 = 1'b0; b_addr0 = 4'h5;
      sb.push_back('{who: 1'b0, rd: 1'b1, data: sh[5]});
      @(negedge clk);
      n = cyc;
      n_cmp++;
      if (b_gnt0 !== 1'b1) begin
         n_err++;
         $display("FAIL early_drop_gnt: got %b want 1", b_gnt0);
      end
      @(posedge clk); #1 b_req0 = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({b_mem_enable, b_mem_address, b_busy} !== {1'b1, 4'h5, 1'b1}) begin
         n_err++;
         $display("FAIL early_drop_issue: got %h want %h", {b_mem_enable, b_mem_address, b_busy}, {1'b1, 4'h5, 1'b1});
      end
      wait_ack(1'b1, at, ok);
      n_cmp++;
      if (at !== n + 5) begin
         n_err++;
         $display("FAIL early_drop_ack_cycle: got %0d want %0d", at, n + 5);
      end
      if (ok) begin
         e = sb.pop_front();
         n_cmp++;
         if ({b_ack0, b_ack1, b_rdata0} !== {1'b1, 1'b0, e.data}) begin
            n_err++;
            $display("FAIL early_drop_rdata: got %h want %h", {b_ack0, b_ack1, b_rdata0}, {1'b1, 1'b0, e.data});
         end
      end
      @(negedge clk);
      n_cmp++;
      if ({b_ack0, b_busy, b_gnt0} !== 3'b000) begin
         n_err++;
         $display("FAIL early_drop_idle: got %b want 000", {b_ack0, b_busy, b_gnt0});
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      req0 = 1'b0; rw0 = 1'b0; addr0 = 4'h0; wdata0 = 4'h0;
      req1 = 1'b0; rw1 = 1'b0; addr1 = 4'h0; wdata1 = 4'h0;
      b_req0 = 1'b0; b_rw0 = 1'b0; b_addr0 = 4'h0; b_wdata0 = 4'h0;
      b_req1 = 1'b0; b_rw1 = 1'b0; b_addr1 = 4'h0; b_wdata1 = 4'h0;
      model_reset();
      test_reset();
      test_read();
      test_write();
      test_reset_mid();
      test_contention();
      test_back_to_back();
      test_early_drop();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
